// File: rtl/buffer_pkg.sv
// Shared constants, FSM state encoding and count clamp for the MEM-stage load buffers.
package buffer_pkg;

    localparam int BUF_DEPTH  = 32;
    localparam int BUF_ADDR_W = 5;
    localparam logic [5:0] COUNT_MAX = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } fill_state_e;

    function automatic logic [5:0] clamp_count(input logic [5:0] raw);
        if (raw > COUNT_MAX) begin
            clamp_count = COUNT_MAX;
        end else begin
            clamp_count = raw;
        end
    endfunction

endpackage

// File: rtl/buffer_regfile.sv
// 32-entry buffer storage: fill and store write ports (store wins), one async read port.
// Optional write-to-read forwarding when BUF_WR_BYPASS_EN is defined.
module buffer_regfile
    import buffer_pkg::*;
#(
    parameter int DEPTH  = BUF_DEPTH,
    parameter int DATA_W = 32,
    parameter int ADDR_W = BUF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_we,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              st_we,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_data_s;

    // Entry update: the core store overrides a fill landing on the same index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (st_we && (st_addr == ADDR_W'(i))) begin
                    mem_r[i] <= st_data;
                end else if (fill_we && (fill_addr == ADDR_W'(i))) begin
                    mem_r[i] <= fill_data;
                end
            end
        end
    end

    // Read port, with same-cycle forwarding of incoming writes when enabled.
    always_comb begin
        rd_data_s = mem_r[rd_addr];
`ifdef BUF_WR_BYPASS_EN
        if (st_we && (st_addr == rd_addr)) begin
            rd_data_s = st_data;
        end else if (fill_we && (fill_addr == rd_addr)) begin
            rd_data_s = fill_data;
        end else begin
            rd_data_s = mem_r[rd_addr];
        end
`endif
    end

    assign rd_data = rd_data_s;

endmodule

// File: rtl/buffer_fill_engine.sv
// Copy engine + core store port for one MEM-stage load buffer.
// Build option BUF_WR_BYPASS_EN forwards same-cycle writes onto buf_rd_data.
module buffer_fill_engine
    import buffer_pkg::*;
#(
    parameter int DEPTH  = BUF_DEPTH,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              start,
    input  logic [31:0]       src_base,
    input  logic [4:0]        dst_base,
    input  logic [5:0]        count,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [4:0]        buf_rd_addr,
    output logic [DATA_W-1:0] buf_rd_data,
    output logic              busy,
    output logic              done
);

    fill_state_e state_r;
    logic [31:0] src_addr_r;
    logic [4:0]  dst_idx_r;
    logic [5:0]  remain_r;
    logic        mem_req_r;
    logic        busy_r;
    logic        done_r;
    logic [5:0]  count_clamped_s;
    logic        fill_we_s;

    assign count_clamped_s = clamp_count(count);
    // Only the single outstanding request can return data, so rvalid outside WAIT is dropped.
    assign fill_we_s       = (state_r == ST_WAIT) && mem_rvalid;

    // Fill sequencer: state, address/count registers and registered handshake outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r    <= ST_IDLE;
            src_addr_r <= 32'h0000_0000;
            dst_idx_r  <= 5'd0;
            remain_r   <= 6'd0;
            mem_req_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        busy_r <= 1'b1;
                        if (count_clamped_s != 6'd0) begin
                            src_addr_r <= src_base;
                            dst_idx_r  <= dst_base;
                            remain_r   <= count_clamped_s;
                            mem_req_r  <= 1'b1;
                            state_r    <= ST_REQ;
                        end else begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req_r <= 1'b0;
                        state_r   <= ST_WAIT;
                    end else begin
                        mem_req_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mem_rvalid) begin
                        src_addr_r <= src_addr_r + 32'd4;
                        dst_idx_r  <= dst_idx_r + 5'd1;
                        remain_r   <= remain_r - 6'd1;
                        if (remain_r == 6'd1) begin
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            mem_req_r <= 1'b1;
                            state_r   <= ST_REQ;
                        end
                    end else begin
                        mem_req_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    mem_req_r <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = src_addr_r;
    assign busy     = busy_r;
    assign done     = done_r;

    buffer_regfile #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (BUF_ADDR_W)
    ) u_regfile (
        .clk       (Clk),
        .rst_n     (Rst_n),
        .fill_we   (fill_we_s),
        .fill_addr (dst_idx_r),
        .fill_data (mem_rdata),
        .st_we     (wr_en),
        .st_addr   (wr_addr),
        .st_data   (wr_data),
        .rd_addr   (buf_rd_addr),
        .rd_data   (buf_rd_data)
    );

endmodule

// File: tb/tb_buffer_fill_engine.sv
// Randomized self-checking bench for buffer_fill_engine against a transaction-level buffer model.
module tb_buffer_fill_engine;

    logic        Clk;
    logic        Rst_n;
    logic        start;
    logic [31:0] src_base;
    logic [4:0]  dst_base;
    logic [5:0]  count;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  buf_rd_addr;
    logic [31:0] buf_rd_data;
    logic        busy;
    logic        done;

    buffer_fill_engine dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .start       (start),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .count       (count),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .busy        (busy),
        .done        (done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [31:0] model [32];
    logic [31:0] exp_src;
    logic [4:0]  exp_dst;
    int          exp_n;
    int          cyc;
    int          exp_cyc;
    int          last_done_cyc;
    bit          fill_fire;
    logic [4:0]  fill_idx;
    bit          quiet;
    bit          inject_start;
    int          n_checks;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: check the read port before the edge, then apply this cycle's writes to the model.
    task automatic cycle();
        logic [31:0] exp;
        #1;
        exp = model[buf_rd_addr];
`ifdef BUF_WR_BYPASS_EN
        if (Rst_n && fill_fire && (fill_idx == buf_rd_addr)) exp = mem_rdata;
        if (Rst_n && wr_en && (wr_addr == buf_rd_addr)) exp = wr_data;
`endif
        check_eq("rd_port", buf_rd_data, exp);
        @(posedge Clk);
        if (Rst_n) begin
            if (fill_fire) model[fill_idx] = mem_rdata;
            if (wr_en) model[wr_addr] = wr_data;
        end
        cyc++;
        #1;
    endtask

    task automatic noise();
        logic [31:0] r;
        r = $urandom();
        buf_rd_addr = r[11:7];
        if (quiet) begin
            wr_en = 1'b0;
            start = inject_start;
            src_base = 32'hDEAD_0000;
            count = 6'd5;
        end else begin
            wr_en = (r[1:0] == 2'b00);
            wr_addr = r[6:2];
            wr_data = $urandom();
            start = (r[14:12] == 3'b000);
            src_base = $urandom();
            dst_base = r[19:15];
            count = r[25:20];
        end
    endtask

    task automatic start_fill(input logic [31:0] s, input logic [4:0] d, input logic [5:0] c);
        exp_src = s;
        exp_dst = d;
        exp_n = (c > 6'd32) ? 32 : int'(c);
        start = 1'b1;
        src_base = s;
        dst_base = d;
        count = c;
        wr_en = 1'b0;
        fill_fire = 1'b0;
        cyc = 0;
        exp_cyc = 1;
        cycle();
        start = 1'b0;
        check_eq("start_busy", {31'd0, busy}, 32'd1);
        check_eq("start_req", {31'd0, mem_req}, (exp_n != 0) ? 32'd1 : 32'd0);
        check_eq("start_done", {31'd0, done}, (exp_n == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic do_word(input int k, input int gd, input int rd, input logic [31:0] data, input bit collide);
        logic [31:0] a;
        a = exp_src + 32'(4 * k);
        for (int d = 0; d < gd; d++) begin
            noise();
            mem_gnt = 1'b0;
            check_eq("req_hold", {31'd0, mem_req}, 32'd1);
            check_eq("addr_hold", mem_addr, a);
            cycle();
        end
        noise();
        check_eq("req", {31'd0, mem_req}, 32'd1);
        check_eq("addr", mem_addr, a);
        mem_gnt = 1'b1;
        cycle();
        mem_gnt = 1'b0;
        for (int r = 0; r < rd; r++) begin
            noise();
            check_eq("req_wait", {31'd0, mem_req}, 32'd0);
            cycle();
        end
        noise();
        mem_rvalid = 1'b1;
        mem_rdata = data;
        fill_fire = 1'b1;
        fill_idx = exp_dst + 5'(k);
        if (collide) begin
            wr_en = 1'b1;
            wr_addr = fill_idx;
            wr_data = 32'h0000_2222;
        end
        cycle();
        mem_rvalid = 1'b0;
        fill_fire = 1'b0;
        exp_cyc += gd + rd + 2;
        check_eq("word_busy", {31'd0, busy}, 32'd1);
        check_eq("word_req", {31'd0, mem_req}, (k != exp_n - 1) ? 32'd1 : 32'd0);
        check_eq("word_done", {31'd0, done}, (k == exp_n - 1) ? 32'd1 : 32'd0);
    endtask

    task automatic check_all();
        wr_en = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            buf_rd_addr = 5'(i);
            cycle();
        end
    endtask

    task automatic finish_fill();
        check_eq("done_cycle", cyc, exp_cyc);
        check_eq("done_pulse", {31'd0, done}, 32'd1);
        last_done_cyc = cyc;
        noise();
        cycle();
        wr_en = 1'b0;
        start = 1'b0;
        check_eq("idle_done", {31'd0, done}, 32'd0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        check_eq("idle_req", {31'd0, mem_req}, 32'd0);
        check_all();
    endtask

    task automatic run_fill(input logic [31:0] s, input logic [4:0] d, input logic [5:0] c,
                            input bit q, input logic [31:0] data_base, input int collide_k);
        int gd;
        int rd;
        logic [31:0] data;
        quiet = q;
        start_fill(s, d, c);
        for (int k = 0; k < exp_n; k++) begin
            gd = q ? 0 : int'($urandom_range(2, 0));
            rd = q ? 0 : int'($urandom_range(2, 0));
            data = (data_base != 32'd0) ? data_base + 32'(k) : $urandom();
            do_word(k, gd, rd, data, k == collide_k);
        end
        finish_fill();
        quiet = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
        wr_en = 1'b0;
        buf_rd_addr = a;
        #1;
        check_eq(tag, buf_rd_data, exp);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [31:0] old7;
        n_checks = 0;
        n_fail = 0;
        quiet = 1'b0;
        inject_start = 1'b0;
        fill_fire = 1'b0;
        fill_idx = 5'd0;
        Rst_n = 1'b0;
        start = 1'b0;
        src_base = 32'd0;
        dst_base = 5'd0;
        count = 6'd0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        wr_en = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'd0;
        buf_rd_addr = 5'd0;
        cyc = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        #12;
        check_eq("rst_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        Rst_n = 1'b1;
        check_all();

        // Basic fill, zero-wait memory.
        run_fill(32'h0000_0100, 5'd0, 6'd4, 1'b1, 32'h0000_00A0, -1);
        check_eq("basic_done_cyc", last_done_cyc, 32'd9);
        for (int i = 0; i < 4; i++) peek("basic_entry", 5'(i), 32'h0000_00A0 + 32'(i));

        // Destination wrap with repeated ignored starts while busy.
        inject_start = 1'b1;
        run_fill(32'h0000_0200, 5'd30, 6'd4, 1'b1, 32'h0000_00B0, -1);
        inject_start = 1'b0;
        peek("wrap_30", 5'd30, 32'h0000_00B0);
        peek("wrap_31", 5'd31, 32'h0000_00B1);
        peek("wrap_0", 5'd0, 32'h0000_00B2);
        peek("wrap_1", 5'd1, 32'h0000_00B3);
        peek("wrap_2_kept", 5'd2, 32'h0000_00A2);

        // Zero count.
        run_fill(32'h0000_0300, 5'd9, 6'd0, 1'b1, 32'd0, -1);
        check_eq("zero_done_cyc", last_done_cyc, 32'd1);

        // Fill/store collision on index 5.
        run_fill(32'h0000_0400, 5'd5, 6'd1, 1'b1, 32'h0000_1111, 0);
        peek("collide", 5'd5, 32'h0000_2222);

        // Randomized fills, including clamp and source address wrap.
        run_fill(32'hFFFF_FFF0, 5'd3, 6'd40, 1'b0, 32'd0, -1);
        for (int t = 0; t < 6; t++) begin
            logic [31:0] s;
            s = $urandom();
            s[1:0] = 2'b00;
            run_fill(s, 5'($urandom_range(31, 0)), 6'($urandom_range(63, 0)), 1'b0, 32'd0, -1);
        end

        // Store forwarding to the read port.
        old7 = model[7];
        wr_en = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'h0000_DEAD;
        buf_rd_addr = 5'd7;
        #1;
`ifdef BUF_WR_BYPASS_EN
        check_eq("bypass_same", buf_rd_data, 32'h0000_DEAD);
`else
        check_eq("nobypass_old", buf_rd_data, old7);
`endif
        cycle();
        wr_en = 1'b0;
        #1;
        check_eq("store_next", buf_rd_data, 32'h0000_DEAD);

        // Reset during WAIT of word 2.
        quiet = 1'b1;
        start_fill(32'h0000_4000, 5'd10, 6'd4);
        do_word(0, 0, 0, 32'h0000_00C0, 1'b0);
        do_word(1, 0, 0, 32'h0000_00C1, 1'b0);
        check_eq("rst_mid_req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        cycle();
        mem_gnt = 1'b0;
        Rst_n = 1'b0;
        #1;
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mid_req0", {31'd0, mem_req}, 32'd0);
        check_eq("rst_mid_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        cycle();
        cycle();
        #2;
        Rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h00BA_DBAD;
        cycle();
        mem_rvalid = 1'b0;
        check_eq("late_rvalid_busy", {31'd0, busy}, 32'd0);
        check_eq("late_rvalid_req", {31'd0, mem_req}, 32'd0);
        quiet = 1'b0;
        check_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
